// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single memory port of the core between instruction fetch (IF,
//   read-only) and the load/store stage (D, read/write). Only one transaction
//   is in flight at a time. D has fixed priority. A starvation guard forces an
//   IF grant after MAX_DWIN consecutive D grants while IF is waiting. A BUSY
//   transaction that gets no mem_ack within TIMEOUT cycles is aborted with err.
// Ports
//   clk, reset                      : rising-edge clock, synchronous active-high reset
//   if_req/if_addr -> if_ack/if_rdata        : fetch requester (read-only)
//   d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata : load/store requester
//   err                             : flags an aborted (timed-out) transaction with its ack
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata : memory port
//   busy                            : FSM is not IDLE
// All outputs are registered. Each output's next value is computed in the
// always_comb block, and the always_ff block registers it.
module mem_port_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_DWIN = 4,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned SCW = (MAX_DWIN < 1) ? 1 : $clog2(MAX_DWIN + 1);
  localparam int unsigned TCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  state_t         state, state_nxt;
  owner_t         owner, owner_nxt;
  logic [SCW-1:0] scnt, scnt_nxt;
  logic [TCW-1:0] tcnt, tcnt_nxt;

  logic           if_ack_nxt, d_ack_nxt, err_nxt, busy_nxt;
  logic [DW-1:0]  if_rdata_nxt, d_rdata_nxt;
  logic           mem_req_nxt, mem_we_nxt;
  logic [AW-1:0]  mem_addr_nxt;
  logic [DW-1:0]  mem_wdata_nxt;

  logic           d_wins;
  logic           timeout_hit;
  logic [DW-1:0]  resp_data;

  // D wins by default; IF takes the port once D has won MAX_DWIN times in a row
  assign d_wins      = d_req && !(if_req && (scnt == SCW'(MAX_DWIN)));
  assign timeout_hit = (tcnt == TCW'(TIMEOUT - 1));
  // Stores return zero data to the requester
  assign resp_data   = mem_we ? '0 : mem_rdata;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_NONE;
      scnt      <= '0;
      tcnt      <= '0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      scnt      <= scnt_nxt;
      tcnt      <= tcnt_nxt;
      if_ack    <= if_ack_nxt;
      if_rdata  <= if_rdata_nxt;
      d_ack     <= d_ack_nxt;
      d_rdata   <= d_rdata_nxt;
      err       <= err_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    scnt_nxt      = scnt;
    tcnt_nxt      = tcnt;
    if_ack_nxt    = 1'b0;
    d_ack_nxt     = 1'b0;
    err_nxt       = 1'b0;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;

    unique case (state)
      IDLE: begin
        if (!if_req) begin
          scnt_nxt = '0;
        end
        if (d_wins) begin
          owner_nxt     = OWN_D;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          tcnt_nxt      = '0;
          state_nxt     = BUSY;
          // d_wins with if_req implies scnt < MAX_DWIN, so this cannot overflow
          if (if_req) begin
            scnt_nxt = scnt + SCW'(1);
          end
        end else if (if_req) begin
          owner_nxt     = OWN_IF;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = 1'b0;
          mem_addr_nxt  = if_addr;
          mem_wdata_nxt = '0;
          tcnt_nxt      = '0;
          scnt_nxt      = '0;
          state_nxt     = BUSY;
        end
      end

      BUSY: begin
        // A late mem_ack in the final cycle beats the timeout
        if (mem_ack || timeout_hit) begin
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          err_nxt     = !mem_ack;
          state_nxt   = RESP;
          if (owner == OWN_IF) begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = mem_ack ? resp_data : '0;
          end else begin
            d_ack_nxt   = 1'b1;
            d_rdata_nxt = mem_ack ? resp_data : '0;
          end
        end else begin
          tcnt_nxt = tcnt + TCW'(1);
        end
      end

      RESP: begin
        // The ack pulse and err are already on the outputs this cycle
        owner_nxt = OWN_NONE;
        state_nxt = IDLE;
      end

      default: begin
        owner_nxt   = OWN_NONE;
        mem_req_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
